// File: rtl/std_cache_pkg.sv
// std_cache_pkg: shared scrub FSM states and counter width for the data-cache scrubber
package std_cache_pkg;
    typedef enum logic [2:0] {IDLE, PENDING, READ, CHECK, WRITE} scrub_state_e;
    localparam int CNT_WIDTH = 16;
endpackage

// File: rtl/dcache_scrub_sched.sv
// dcache_scrub_sched: periodic ECC scrub scheduler that walks every line of all ways and writes back corrected data
module dcache_scrub_sched
    import std_cache_pkg::*;
#(
    parameter int NumWays       = 8,
    parameter int NumLines      = 256,
    parameter int ScrubInterval = 1024,
    parameter int MaxStall      = 16,
    parameter int CntWidth      = CNT_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        scrub_en_i,
    input  logic                        intc_req_i,
    output logic                        scrub_active_o,
    output logic [NumWays-1:0]          scrub_req_o,
    output logic                        scrub_we_o,
    output logic [$clog2(NumLines)-1:0] scrub_addr_o,
    input  logic [NumWays-1:0]          ecc_single_err_i,
    input  logic [NumWays-1:0]          ecc_double_err_i,
    output logic [CntWidth-1:0]         corrected_cnt_o,
    output logic [CntWidth-1:0]         uncorrectable_cnt_o,
    output logic                        uncorrectable_o,
    output logic                        pass_done_o
);
    localparam int AW = $clog2(NumLines);
    localparam int IW = $clog2(ScrubInterval + 1);
    localparam int SW = $clog2(MaxStall + 1);

    scrub_state_e state, state_nxt;
    logic [IW-1:0] int_cnt;
    logic [SW-1:0] stall_cnt;
    logic [NumWays-1:0] fix_mask;
    logic dbl, sgl, adv;

    assign dbl = |ecc_double_err_i;
    assign sgl = |ecc_single_err_i;
    // A line is finished when CHECK exits without a write-back, or after WRITE.
    assign adv = (state == CHECK && !(sgl && !dbl)) || state == WRITE;

    assign scrub_active_o = state inside {READ, CHECK, WRITE};
    assign scrub_we_o     = state == WRITE;
    assign scrub_req_o    = state == READ ? '1 : state == WRITE ? fix_mask : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = scrub_en_i && int_cnt == IW'(ScrubInterval - 1) ? PENDING : IDLE;
            PENDING: state_nxt = !scrub_en_i ? IDLE :
                                 !intc_req_i || stall_cnt == SW'(MaxStall - 1) ? READ : PENDING;
            READ:    state_nxt = CHECK;
            CHECK:   state_nxt = sgl && !dbl ? WRITE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state               <= IDLE;
            int_cnt             <= '0;
            stall_cnt           <= '0;
            fix_mask            <= '0;
            scrub_addr_o        <= '0;
            corrected_cnt_o     <= '0;
            uncorrectable_cnt_o <= '0;
            uncorrectable_o     <= 1'b0;
            pass_done_o         <= 1'b0;
        end else begin
            state     <= state_nxt;
            int_cnt   <= state == IDLE && state_nxt == IDLE && scrub_en_i ? int_cnt + IW'(1) : '0;
            stall_cnt <= state == PENDING && state_nxt == PENDING ? stall_cnt + SW'(1) : '0;
            if (state == CHECK)
                fix_mask <= ecc_single_err_i;
            if (state == CHECK && sgl && !dbl)
                corrected_cnt_o <= corrected_cnt_o + CntWidth'(~&corrected_cnt_o);
            if (state == CHECK && dbl)
                uncorrectable_cnt_o <= uncorrectable_cnt_o + CntWidth'(~&uncorrectable_cnt_o);
            uncorrectable_o <= state == CHECK && dbl;
            pass_done_o     <= adv && scrub_addr_o == AW'(NumLines - 1);
            if (adv)
                scrub_addr_o <= scrub_addr_o + AW'(1);
        end
    end
endmodule

// File: tb/tb_dcache_scrub_sched.sv
// tb_dcache_scrub_sched: directed and randomized scrub operations checked against a transaction-level model
module tb_dcache_scrub_sched;
    localparam int NW = 8, NL = 4, SI = 4, MS = 16, CW = 3;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 0, rst = 1, en = 0, intc = 0;
    logic [NW-1:0] sgl_err = '0, dbl_err = '0;
    logic active, we, unc_o, pass_done;
    logic [NW-1:0] req;
    logic [$clog2(NL)-1:0] addr;
    logic [CW-1:0] corr_cnt, unc_cnt;

    int checks = 0, errors = 0;
    int exp_line = 0, exp_corr = 0, exp_unc = 0;

    always #5 clk = ~clk;

    dcache_scrub_sched #(.NumWays(NW), .NumLines(NL), .ScrubInterval(SI), .MaxStall(MS), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst), .scrub_en_i(en), .intc_req_i(intc),
        .scrub_active_o(active), .scrub_req_o(req), .scrub_we_o(we), .scrub_addr_o(addr),
        .ecc_single_err_i(sgl_err), .ecc_double_err_i(dbl_err),
        .corrected_cnt_o(corr_cnt), .uncorrectable_cnt_o(unc_cnt),
        .uncorrectable_o(unc_o), .pass_done_o(pass_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int sat(input int v);
        return v >= SAT ? SAT : v + 1;
    endfunction

    // Cycles from the first idle cycle to READ: SI counting cycles, then the
    // pending wait ends at the first quiet cycle or after MS cycles of yielding.
    function automatic int exp_lat(input logic [31:0] pat);
        for (int j = 0; j < MS; j++)
            if (!pat[SI + j] || j == MS - 1) return SI + 1 + j;
        return -1;
    endfunction

    task automatic wait_read(input logic [31:0] pat, input string tag);
        int c = 0;
        intc = pat[0];
        while (!(active && req == '1) && c < 200) begin
            tick();
            c++;
            intc = c < 32 ? pat[c] : 1'b0;
        end
        chk(tag, c, exp_lat(pat));
    endtask

    task automatic check_line_done(input string tag);
        exp_line = (exp_line + 1) % NL;
        chk({tag, "_addr"}, addr, exp_line);
        chk({tag, "_pass"}, pass_done, exp_line == 0);
        chk({tag, "_idle"}, active, 0);
    endtask

    task automatic do_op(input logic [NW-1:0] s, input logic [NW-1:0] d, input string tag);
        intc = 0;
        chk({tag, "_rd_addr"}, addr, exp_line);
        chk({tag, "_rd_we"}, we, 0);
        tick();
        chk({tag, "_ck_act"}, active, 1);
        chk({tag, "_ck_req"}, req, 0);
        sgl_err = s;
        dbl_err = d;
        tick();
        sgl_err = '0;
        dbl_err = '0;
        if (d != 0) begin
            exp_unc = sat(exp_unc);
            chk({tag, "_unc_pulse"}, unc_o, 1);
            chk({tag, "_unc_cnt"}, unc_cnt, exp_unc);
            chk({tag, "_no_we"}, we, 0);
            check_line_done(tag);
        end else if (s != 0) begin
            exp_corr = sat(exp_corr);
            chk({tag, "_wr_req"}, req, s);
            chk({tag, "_wr_we"}, we, 1);
            chk({tag, "_wr_addr"}, addr, exp_line);
            tick();
            check_line_done(tag);
            chk({tag, "_unc_pulse"}, unc_o, 0);
        end else begin
            chk({tag, "_unc_pulse"}, unc_o, 0);
            check_line_done(tag);
        end
        chk({tag, "_corr_cnt"}, corr_cnt, exp_corr);
        chk({tag, "_unc_cnt_end"}, unc_cnt, exp_unc);
    endtask

    task automatic quiet(input int n, input string tag);
        int hits = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            hits += int'(active) + int'(req != 0);
        end
        chk(tag, hits, 0);
    endtask

    initial begin
        tick();
        tick();
        rst = 0;
        chk("rst_active", active, 0);
        chk("rst_req", req, 0);
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_corr", corr_cnt, 0);
        chk("rst_unc", unc_cnt, 0);
        chk("rst_unc_pulse", unc_o, 0);
        chk("rst_pass", pass_done, 0);
        en = 1;
        wait_read(0, "first_read_lat");
        chk("first_read_req", req, 8'hFF);
        do_op(0, 0, "clean");
        wait_read(0, "lat2");
        do_op(8'h04, 0, "single");
        wait_read(0, "lat3");
        do_op(8'h02, 8'h01, "double_prio");
        wait_read('1, "stall_forced");
        do_op(0, 0, "wrap");
        // Scrub enable withdrawn while pending: back to idle with no access.
        intc = 1;
        repeat (SI) tick();
        chk("pend_inactive", active, 0);
        en = 0;
        quiet(30, "pend_abort_quiet");
        en = 1;
        wait_read(0, "reenable_lat");
        do_op(0, 0, "after_reenable");
        // Enable withdrawn mid-operation: the line completes, then stays idle.
        wait_read(0, "lat_mid");
        en = 0;
        do_op(8'h10, 0, "mid_disable");
        quiet(30, "mid_disable_quiet");
        en = 1;
        wait_read(0, "lat_rst");
        tick();
        sgl_err = 8'h08;
        rst = 1;
        tick();
        sgl_err = '0;
        rst = 0;
        exp_line = 0;
        exp_corr = 0;
        exp_unc = 0;
        chk("ckrst_active", active, 0);
        chk("ckrst_we", we, 0);
        chk("ckrst_req", req, 0);
        chk("ckrst_addr", addr, 0);
        chk("ckrst_corr", corr_cnt, 0);
        chk("ckrst_unc", unc_cnt, 0);
        wait_read(0, "post_rst_lat");
        do_op(0, 0, "post_rst");
        for (int i = 0; i <= SAT; i++) begin
            wait_read(0, "sat_lat");
            do_op(0, 8'h80, "sat_unc");
        end
        for (int i = 0; i <= SAT; i++) begin
            wait_read(0, "sat_lat");
            do_op(8'h01, 0, "sat_corr");
        end
        for (int i = 0; i < 40; i++) begin
            logic [31:0] pat;
            logic [NW-1:0] s, d;
            int kind;
            pat = $urandom;
            kind = $urandom_range(0, 3);
            s = kind[0] ? NW'($urandom_range(1, (1 << NW) - 1)) : '0;
            d = kind[1] ? NW'($urandom_range(1, (1 << NW) - 1)) : '0;
            wait_read(pat, "rnd_lat");
            do_op(s, d, "rnd");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
